ra_pq_p: RTL and testbench

Parametrised register-array hardware priority queue, the generalised successor to the fixed-size sorted-register queue in the HWPQ study. It holds up to DEPTH key/value entries sorted in an array of cells, with configurable key and value widths and min-first or max-first ordering. It supports enqueue, dequeue and a single-cycle replace (simultaneous pop and push), with FIFO ordering among equal keys. It sits under the same simulation top and testbench style as the other HWPQ variants.

---
 rtl/pq_pkg.sv | 26 ++
 rtl/ra_pq_cell.sv | 93 +++++++++
 rtl/ra_pq_p.sv | 154 +++++++++++++++
 tb/tb_ra_pq_p.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared types, defaults and ordering helper for the register-array priority queue
//
// Contents:
//   pq_op_t  operation applied to every cell in a cycle (NOP/ENQ/DEQ/REPL)
//   PQ_*     default DEPTH/KW/VW for the top
//   better() strict ordering test; equal keys are never better, which keeps FIFO order among ties
package pq_pkg;

  typedef enum logic [1:0] {
    PQ_NOP  = 2'd0,
    PQ_ENQ  = 2'd1,
    PQ_DEQ  = 2'd2,
    PQ_REPL = 2'd3
  } pq_op_t;

  localparam int PQ_DEPTH = 16;
  localparam int PQ_KW    = 16;
  localparam int PQ_VW    = 16;

  // Keys are zero-extended to 64 bits by the caller so one function serves any KW <= 64.
  function automatic logic better(input logic [63:0] a, input logic [63:0] b,
                                  input logic min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/ra_pq_cell.sv
// rtl/ra_pq_cell.sv - one slot of the sorted register array
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   op                        operation decoded by the top for this cycle
//   new_key/new_val           entry being inserted
//   left_*/right_*            neighbour contents (tied invalid/zero at the array ends)
//   cmp_own                   ENQ/DEQ: this cell is not worse than the new key
//                             REPL: the right neighbour is not worse than the new key
//   cmp_left                  ENQ/DEQ: left neighbour's compare bit (1 for cell 0)
//                             REPL: this cell's compare bit (1 for cell 0)
//   vld_q/key_q/val_q         registered slot contents
module ra_pq_cell
  import pq_pkg::*;
#(
  parameter int KW = PQ_KW,
  parameter int VW = PQ_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  pq_op_t        op,
  input  logic [KW-1:0] new_key,
  input  logic [VW-1:0] new_val,
  input  logic          left_vld,
  input  logic [KW-1:0] left_key,
  input  logic [VW-1:0] left_val,
  input  logic          right_vld,
  input  logic [KW-1:0] right_key,
  input  logic [VW-1:0] right_val,
  input  logic          cmp_own,
  input  logic          cmp_left,
  output logic          vld_q,
  output logic [KW-1:0] key_q,
  output logic [VW-1:0] val_q
);

  logic          vld_d;
  logic [KW-1:0] key_d;
  logic [VW-1:0] val_d;

  // The compare bits form a thermometer over the valid cells, so the 1->0
  // edge between cmp_left and cmp_own marks the insertion slot.
  always_comb begin
    vld_d = vld_q;
    key_d = key_q;
    val_d = val_q;
    case (op)
      PQ_ENQ: begin
        if (!cmp_own) begin
          if (cmp_left) begin
            vld_d = 1'b1;
            key_d = new_key;
            val_d = new_val;
          end else begin
            vld_d = left_vld;
            key_d = left_key;
            val_d = left_val;
          end
        end
      end
      PQ_DEQ: begin
        vld_d = right_vld;
        key_d = right_key;
        val_d = right_val;
      end
      PQ_REPL: begin
        if (cmp_own) begin
          vld_d = right_vld;
          key_d = right_key;
          val_d = right_val;
        end else if (cmp_left) begin
          vld_d = 1'b1;
          key_d = new_key;
          val_d = new_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      key_q <= '0;
      val_q <= '0;
    end else begin
      vld_q <= vld_d;
      key_q <= key_d;
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/ra_pq_p.sv
// rtl/ra_pq_p.sv - parametrised register-array priority queue with enqueue, dequeue and replace
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enq, ki, vi  push request and entry
//   deq          pop request for the head
//   ko, vo       head entry (0 when empty)
//   empty, full  occupancy flags
//   count        number of valid entries
//   err          one-cycle pulse after a dropped request
module ra_pq_p
  import pq_pkg::*;
#(
  parameter int DEPTH     = PQ_DEPTH,
  parameter int KW        = PQ_KW,
  parameter int VW        = PQ_VW,
  parameter int MIN_FIRST = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic          deq,
  input  logic [KW-1:0] ki,
  input  logic [VW-1:0] vi,
  output logic [KW-1:0] ko,
  output logic [VW-1:0] vo,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam logic MIN_BIT = (MIN_FIRST != 0);

  pq_op_t        op;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          empty_q, full_q;

  logic [DEPTH-1:0] vld;
  logic [KW-1:0]    key [DEPTH];
  logic [VW-1:0]    val [DEPTH];
  // cmp[i]: cell i is valid and not worse than ki; cmp[DEPTH] is the empty slot past the end.
  logic [DEPTH:0]   cmp;

  assign cmp[DEPTH] = 1'b0;

  // A push with a pop while empty still goes in; only the pop is reported as dropped.
  always_comb begin
    op      = PQ_NOP;
    err_d   = 1'b0;
    count_d = count_q;
    if (enq && deq) begin
      if (empty_q) begin
        op      = PQ_ENQ;
        err_d   = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
        op = PQ_REPL;
      end
    end else if (enq) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        op      = PQ_ENQ;
        count_d = count_q + CW'(1);
      end
    end else if (deq) begin
      if (empty_q) begin
        err_d = 1'b1;
      end else begin
        op      = PQ_DEQ;
        count_d = count_q - CW'(1);
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic          l_vld, r_vld;
    logic [KW-1:0] l_key, r_key;
    logic [VW-1:0] l_val, r_val;
    logic          c_own, c_left;

    assign cmp[i] = vld[i] & ~better(64'(ki), 64'(key[i]), MIN_BIT);

    if (i == 0) begin : g_left_end
      assign l_vld  = 1'b0;
      assign l_key  = '0;
      assign l_val  = '0;
      assign c_left = 1'b1;
    end else begin : g_left_nb
      assign l_vld  = vld[i-1];
      assign l_key  = key[i-1];
      assign l_val  = val[i-1];
      assign c_left = (op == PQ_REPL) ? cmp[i] : cmp[i-1];
    end

    if (i == DEPTH - 1) begin : g_right_end
      assign r_vld = 1'b0;
      assign r_key = '0;
      assign r_val = '0;
    end else begin : g_right_nb
      assign r_vld = vld[i+1];
      assign r_key = key[i+1];
      assign r_val = val[i+1];
    end

    // Replace shifts the window one cell right: the head leaves, so each cell
    // looks one position ahead to decide whether it takes its right neighbour.
    assign c_own = (op == PQ_REPL) ? cmp[i+1] : cmp[i];

    ra_pq_cell #(.KW(KW), .VW(VW)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .new_key   (ki),
      .new_val   (vi),
      .left_vld  (l_vld),
      .left_key  (l_key),
      .left_val  (l_val),
      .right_vld (r_vld),
      .right_key (r_key),
      .right_val (r_val),
      .cmp_own   (c_own),
      .cmp_left  (c_left),
      .vld_q     (vld[i]),
      .key_q     (key[i]),
      .val_q     (val[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  assign ko    = vld[0] ? key[0] : '0;
  assign vo    = vld[0] ? val[0] : '0;
  assign count = count_q;
  assign err   = err_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_ra_pq_p.sv
// tb/tb_ra_pq_p.sv - table-driven and scoreboard bench for ra_pq_p
module tb_ra_pq_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enq0, deq0, enq1, deq1;
  logic [7:0] ki0, vi0, ki1, vi1;
  logic [7:0] ko0, vo0, ko1, vo1;
  logic       empty0, full0, err0, empty1, full1, err1;
  logic [2:0] count0, count1;

  ra_pq_p #(.DEPTH(4), .KW(8), .VW(8), .MIN_FIRST(1)) u_min (
    .clk(clk), .rst(rst), .enq(enq0), .deq(deq0), .ki(ki0), .vi(vi0),
    .ko(ko0), .vo(vo0), .empty(empty0), .full(full0), .count(count0), .err(err0)
  );

  ra_pq_p #(.DEPTH(4), .KW(8), .VW(8), .MIN_FIRST(0)) u_max (
    .clk(clk), .rst(rst), .enq(enq1), .deq(deq1), .ki(ki1), .vi(vi1),
    .ko(ko1), .vo(vo1), .empty(empty1), .full(full1), .count(count1), .err(err1)
  );

  typedef struct {
    logic       sel;
    logic       enq;
    logic       deq;
    logic [7:0] k;
    logic [7:0] v;
    int         eko;
    int         evo;
    int         ecnt;
    int         eerr;
  } vec_t;

  typedef struct {
    logic sel;
    int   ko;
    int   vo;
    int   cnt;
    int   err;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   passes = 0;
  int   total  = 0;
  int   mk[$];
  int   mv[$];

  function automatic vec_t mkv(input logic sel, input logic e, input logic d,
                               input int k, input int v, input int eko, input int evo,
                               input int ecnt, input int eerr);
    vec_t r;
    r.sel = sel; r.enq = e; r.deq = d; r.k = 8'(k); r.v = 8'(v);
    r.eko = eko; r.evo = evo; r.ecnt = ecnt; r.eerr = eerr;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic idle();
    enq0 = 0; deq0 = 0; ki0 = 0; vi0 = 0;
    enq1 = 0; deq1 = 0; ki1 = 0; vi1 = 0;
  endtask

  task automatic apply(input logic sel, input logic e, input logic d,
                       input logic [7:0] k, input logic [7:0] v, input exp_t ex);
    exp_t x;
    idle();
    if (sel) begin enq1 = e; deq1 = d; ki1 = k; vi1 = v; end
    else     begin enq0 = e; deq0 = d; ki0 = k; vi0 = v; end
    sbq.push_back(ex);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    if (x.sel) begin
      chk("max_ko", int'(ko1), x.ko);
      chk("max_vo", int'(vo1), x.vo);
      chk("max_count", int'(count1), x.cnt);
      chk("max_err", int'(err1), x.err);
      chk("max_empty", int'(empty1), int'(x.cnt == 0));
      chk("max_full", int'(full1), int'(x.cnt == 4));
    end else begin
      chk("min_ko", int'(ko0), x.ko);
      chk("min_vo", int'(vo0), x.vo);
      chk("min_count", int'(count0), x.cnt);
      chk("min_err", int'(err0), x.err);
      chk("min_empty", int'(empty0), int'(x.cnt == 0));
      chk("min_full", int'(full0), int'(x.cnt == 4));
    end
    idle();
  endtask

  task automatic apply_vec(input vec_t t);
    exp_t ex;
    ex.sel = t.sel; ex.ko = t.eko; ex.vo = t.evo; ex.cnt = t.ecnt; ex.err = t.eerr;
    apply(t.sel, t.enq, t.deq, t.k, t.v, ex);
  endtask

  // Reference model for the min-first instance: a sorted list, new entries
  // inserted in front of the first strictly larger key.
  task automatic model_insert(input int k, input int v);
    int pos;
    pos = mk.size();
    for (int i = 0; i < mk.size(); i++) begin
      if (k < mk[i]) begin pos = i; break; end
    end
    mk.insert(pos, k);
    mv.insert(pos, v);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", int'(empty0), 1);
    chk("reset_count", int'(count0), 0);
    chk("reset_ko", int'(ko0), 0);
    chk("reset_err", int'(err0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Mid-stream asynchronous reset after three pushes.
    tbl = {};
    tbl.push_back(mkv(0, 1, 0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mkv(0, 1, 0, 2, 2, 1, 1, 2, 0));
    tbl.push_back(mkv(0, 1, 0, 3, 3, 1, 1, 3, 0));
    foreach (tbl[i]) apply_vec(tbl[i]);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_empty", int'(empty0), 1);
    chk("async_rst_count", int'(count0), 0);
    chk("async_rst_ko", int'(ko0), 0);
    chk("async_rst_full", int'(full0), 0);
    @(negedge clk);
    rst = 1'b0;

    tbl = {};
    tbl.push_back(mkv(0, 1, 0, 9, 9, 9, 9, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Ordering with FIFO among equal keys.
    tbl.push_back(mkv(0, 1, 0, 30, 1, 30, 1, 1, 0));
    tbl.push_back(mkv(0, 1, 0, 10, 2, 10, 2, 2, 0));
    tbl.push_back(mkv(0, 1, 0, 20, 3, 10, 2, 3, 0));
    tbl.push_back(mkv(0, 1, 0, 10, 4, 10, 2, 4, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 10, 4, 3, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 20, 3, 2, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 30, 1, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Full: push dropped, then replace on a full queue.
    tbl.push_back(mkv(0, 1, 0, 5, 5, 5, 5, 1, 0));
    tbl.push_back(mkv(0, 1, 0, 6, 6, 5, 5, 2, 0));
    tbl.push_back(mkv(0, 1, 0, 7, 7, 5, 5, 3, 0));
    tbl.push_back(mkv(0, 1, 0, 8, 8, 5, 5, 4, 0));
    tbl.push_back(mkv(0, 1, 0, 1, 9, 5, 5, 4, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 5, 5, 4, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 10, 1, 10, 4, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 6, 6, 3, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 7, 7, 2, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 8, 8, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Replace into the middle and at the head.
    tbl.push_back(mkv(0, 1, 0, 10, 1, 10, 1, 1, 0));
    tbl.push_back(mkv(0, 1, 0, 20, 2, 10, 1, 2, 0));
    tbl.push_back(mkv(0, 1, 0, 30, 3, 10, 1, 3, 0));
    tbl.push_back(mkv(0, 1, 1, 25, 4, 20, 2, 3, 0));
    tbl.push_back(mkv(0, 1, 1, 5, 5, 5, 5, 3, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 25, 4, 2, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 30, 3, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Drops while empty.
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 7, 7, 7, 7, 1, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 7, 7, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Max-first instance.
    tbl.push_back(mkv(1, 1, 0, 3, 1, 3, 1, 1, 0));
    tbl.push_back(mkv(1, 1, 0, 9, 2, 9, 2, 2, 0));
    tbl.push_back(mkv(1, 1, 0, 6, 3, 9, 2, 3, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0, 6, 3, 2, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0, 3, 1, 1, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) apply_vec(tbl[i]);

    // Random traffic on the min-first instance against the model.
    mk = {};
    mv = {};
    for (int n = 0; n < 300; n++) begin
      logic e, d;
      int   k, v;
      exp_t ex;
      e = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 7);
      v = n & 8'hff;
      ex.sel = 1'b0;
      ex.err = 0;
      if (e && d) begin
        if (mk.size() == 0) ex.err = 1;
        else begin void'(mk.pop_front()); void'(mv.pop_front()); end
        model_insert(k, v);
      end else if (e) begin
        if (mk.size() == 4) ex.err = 1;
        else model_insert(k, v);
      end else if (d) begin
        if (mk.size() == 0) ex.err = 1;
        else begin void'(mk.pop_front()); void'(mv.pop_front()); end
      end
      ex.cnt = mk.size();
      ex.ko  = (mk.size() != 0) ? mk[0] : 0;
      ex.vo  = (mv.size() != 0) ? mv[0] : 0;
      apply(1'b0, e, d, 8'(k), 8'(v), ex);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
